// File: rtl/mem_bus_master.sv
// CPU-side initiator for the memory store strobe interface.
// Sequences setup, strobe and hold phases around each access.
module mem_bus_master #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 8,
    parameter int SETUP_CYC  = 1,
    parameter int STROBE_CYC = 2,
    parameter int HOLD_CYC   = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run_en,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr_in,
    input  logic [DATA_W-1:0] wdata_in,
    output logic              busy,
    output logic              ack,
    output logic [DATA_W-1:0] rdata,
    output logic              abort,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_read,
    output logic              mem_write,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_STROBE,
        S_HOLD,
        S_DONE
    } state_t;

    localparam logic [3:0] LP_SETUP_LAST  = 4'(SETUP_CYC - 1);
    localparam logic [3:0] LP_STROBE_LAST = 4'(STROBE_CYC - 1);
    localparam logic [3:0] LP_HOLD_LAST   = 4'(HOLD_CYC - 1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [3:0]          r_phase;
    logic [3:0]          w_phase_nxt;
    logic                r_we;
    logic                r_busy;
    logic                r_ack;
    logic                r_abort;
    logic                r_mem_read;
    logic                r_mem_write;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [DATA_W-1:0]   r_mem_wdata;
    logic [DATA_W-1:0]   r_rdata;

    logic                w_accept;
    logic                w_abort;
    logic                w_capture;
    logic                w_busy_nxt;
    logic                w_strobe_nxt;

    always_comb begin
        w_state_nxt = r_state;
        w_phase_nxt = r_phase;
        w_accept    = 1'b0;
        w_abort     = 1'b0;
        w_capture   = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (req && run_en) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_SETUP;
                    w_phase_nxt = 4'd0;
                end
            end
            S_SETUP: begin
                if (!run_en) begin
                    w_abort = 1'b1;
                end else if (r_phase == LP_SETUP_LAST) begin
                    w_state_nxt = S_STROBE;
                    w_phase_nxt = 4'd0;
                end else begin
                    w_phase_nxt = r_phase + 4'd1;
                end
            end
            S_STROBE: begin
                if (!run_en) begin
                    w_abort = 1'b1;
                end else if (r_phase == LP_STROBE_LAST) begin
                    w_capture   = !r_we;
                    w_state_nxt = S_HOLD;
                    w_phase_nxt = 4'd0;
                end else begin
                    w_phase_nxt = r_phase + 4'd1;
                end
            end
            S_HOLD: begin
                if (!run_en) begin
                    w_abort = 1'b1;
                end else if (r_phase == LP_HOLD_LAST) begin
                    w_state_nxt = S_DONE;
                    w_phase_nxt = 4'd0;
                end else begin
                    w_phase_nxt = r_phase + 4'd1;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_phase_nxt = 4'd0;
            end
        endcase
        if (w_abort) begin
            w_state_nxt = S_IDLE;
            w_phase_nxt = 4'd0;
        end
    end

    // Strobes and status flags are registered from the next state so they
    // change only on clock edges and never overlap.
    assign w_busy_nxt   = (w_state_nxt == S_SETUP)
                       || (w_state_nxt == S_STROBE)
                       || (w_state_nxt == S_HOLD);
    assign w_strobe_nxt = (w_state_nxt == S_STROBE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_phase     <= 4'd0;
            r_we        <= 1'b0;
            r_busy      <= 1'b0;
            r_ack       <= 1'b0;
            r_abort     <= 1'b0;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_rdata     <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_phase     <= w_phase_nxt;
            r_busy      <= w_busy_nxt;
            r_ack       <= (w_state_nxt == S_DONE);
            r_abort     <= w_abort;
            r_mem_read  <= w_strobe_nxt && !r_we;
            r_mem_write <= w_strobe_nxt && r_we;
            if (w_accept) begin
                r_we        <= we;
                r_mem_addr  <= addr_in;
                r_mem_wdata <= wdata_in;
            end
            if (w_capture) begin
                r_rdata <= mem_rdata;
            end
        end
    end

    assign busy      = r_busy;
    assign ack       = r_ack;
    assign abort     = r_abort;
    assign rdata     = r_rdata;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign mem_read  = r_mem_read;
    assign mem_write = r_mem_write;

endmodule

// File: tb/tb_mem_bus_master.sv
// Bench for mem_bus_master: default and (3,1,2) timing instances
// against a transaction-offset reference model.
module tb_mem_bus_master;

    logic        clk;
    logic        reset;
    logic        run_en;
    logic        req;
    logic        we;
    logic [15:0] addr_in;
    logic [7:0]  wdata_in;
    logic [7:0]  mem_rdata;

    logic [1:0]  o_busy, o_ack, o_abort, o_rd, o_wr;
    logic [15:0] o_maddr [2];
    logic [7:0]  o_mwd   [2];
    logic [7:0]  o_rdat  [2];

    int n_tests = 0;
    int n_fail  = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    mem_bus_master u0 (
        .clk(clk), .reset(reset), .run_en(run_en), .req(req), .we(we),
        .addr_in(addr_in), .wdata_in(wdata_in),
        .busy(o_busy[0]), .ack(o_ack[0]), .rdata(o_rdat[0]),
        .abort(o_abort[0]), .mem_addr(o_maddr[0]), .mem_wdata(o_mwd[0]),
        .mem_read(o_rd[0]), .mem_write(o_wr[0]), .mem_rdata(mem_rdata)
    );

    mem_bus_master #(.SETUP_CYC(3), .STROBE_CYC(1), .HOLD_CYC(2)) u1 (
        .clk(clk), .reset(reset), .run_en(run_en), .req(req), .we(we),
        .addr_in(addr_in), .wdata_in(wdata_in),
        .busy(o_busy[1]), .ack(o_ack[1]), .rdata(o_rdat[1]),
        .abort(o_abort[1]), .mem_addr(o_maddr[1]), .mem_wdata(o_mwd[1]),
        .mem_read(o_rd[1]), .mem_write(o_wr[1]), .mem_rdata(mem_rdata)
    );

    function automatic int ps(int i); return (i == 0) ? 1 : 3; endfunction
    function automatic int pt(int i); return (i == 0) ? 2 : 1; endfunction
    function automatic int ph(int i); return (i == 0) ? 1 : 2; endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: a transaction is a start edge plus offsets.
    int          cyc;
    bit          m_act   [2];
    int          m_start [2];
    bit          m_we    [2];
    logic [15:0] m_addr  [2];
    logic [7:0]  m_wd    [2];
    logic [7:0]  m_rd    [2];
    bit          m_done  [2];
    bit          m_abort [2];

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            cyc = 0;
            for (int i = 0; i < 2; i++) begin
                m_act[i] = 0; m_start[i] = 0; m_we[i] = 0;
                m_addr[i] = '0; m_wd[i] = '0; m_rd[i] = '0;
                m_done[i] = 0; m_abort[i] = 0;
            end
        end else begin
            cyc++;
            for (int i = 0; i < 2; i++) begin
                bit pd;
                int d;
                pd = m_done[i];
                m_done[i] = 0;
                m_abort[i] = 0;
                if (m_act[i]) begin
                    d = cyc - m_start[i];
                    if (!run_en) begin
                        m_act[i] = 0;
                        m_abort[i] = 1;
                    end else begin
                        if (d == ps(i) + pt(i) && !m_we[i]) m_rd[i] = mem_rdata;
                        if (d == ps(i) + pt(i) + ph(i)) begin
                            m_act[i] = 0;
                            m_done[i] = 1;
                        end
                    end
                end else if (!pd && req && run_en) begin
                    m_act[i] = 1;
                    m_start[i] = cyc;
                    m_we[i] = we;
                    m_addr[i] = addr_in;
                    m_wd[i] = wdata_in;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                int d;
                bit strb;
                d = cyc - m_start[i];
                strb = m_act[i] && d >= ps(i) && d < ps(i) + pt(i);
                chk($sformatf("u%0d busy", i), 32'(o_busy[i]), 32'(m_act[i]));
                chk($sformatf("u%0d ack", i), 32'(o_ack[i]), 32'(m_done[i]));
                chk($sformatf("u%0d abort", i), 32'(o_abort[i]), 32'(m_abort[i]));
                chk($sformatf("u%0d mem_read", i), 32'(o_rd[i]),
                    32'(strb && !m_we[i]));
                chk($sformatf("u%0d mem_write", i), 32'(o_wr[i]),
                    32'(strb && m_we[i]));
                chk($sformatf("u%0d mem_addr", i), 32'(o_maddr[i]), 32'(m_addr[i]));
                chk($sformatf("u%0d mem_wdata", i), 32'(o_mwd[i]), 32'(m_wd[i]));
                chk($sformatf("u%0d rdata", i), 32'(o_rdat[i]), 32'(m_rd[i]));
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(input string nm);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("%s u%0d outs", nm, i),
                32'({o_busy[i], o_ack[i], o_abort[i], o_rd[i], o_wr[i]}), 32'd0);
            chk($sformatf("%s u%0d addr", nm, i), 32'(o_maddr[i]), 32'd0);
            chk($sformatf("%s u%0d data", nm, i),
                32'({o_mwd[i], o_rdat[i]}), 32'd0);
        end
    endtask

    int acks;
    int ack_k [$];

    initial begin
        reset = 1'b0; run_en = 1'b0; req = 1'b0; we = 1'b0;
        addr_in = '0; wdata_in = '0; mem_rdata = '0;
        repeat (3) tick;
        chk_zero("reset");
        reset = 1'b1;
        tick;
        chk("post-reset busy", 32'(o_busy[0]), 32'd0);

        // Read with default and long-setup timing
        run_en = 1'b1; mem_rdata = 8'hA5;
        req = 1'b1; we = 1'b0; addr_in = 16'h0003;
        tick;
        req = 1'b0;
        chk("rd accept busy", 32'(o_busy[0]), 32'd1);
        chk("rd setup strobe", 32'(o_rd[0]), 32'd0);
        chk("rd mem_addr", 32'(o_maddr[0]), 32'h0003);
        tick; chk("rd N+1 strobe", 32'(o_rd[0]), 32'd1);
        tick; chk("rd N+2 strobe", 32'(o_rd[0]), 32'd1);
        tick; chk("rd N+3 strobe", 32'(o_rd[0]), 32'd0);
        chk("rd rdata", 32'(o_rdat[0]), 32'h00A5);
        chk("p312 N+3 strobe", 32'(o_rd[1]), 32'd1);
        tick; chk("rd N+4 ack", 32'(o_ack[0]), 32'd1);
        chk("rd N+4 busy", 32'(o_busy[0]), 32'd0);
        chk("p312 N+4 strobe", 32'(o_rd[1]), 32'd0);
        chk("p312 N+4 ack", 32'(o_ack[1]), 32'd0);
        tick; chk("rd N+5 ack", 32'(o_ack[0]), 32'd0);
        tick; chk("p312 N+6 ack", 32'(o_ack[1]), 32'd1);
        chk("p312 rdata", 32'(o_rdat[1]), 32'h00A5);
        repeat (3) tick;

        // Write: data stable, rdata untouched
        mem_rdata = 8'h77;
        req = 1'b1; we = 1'b1; addr_in = 16'h0020; wdata_in = 8'h5C;
        tick;
        req = 1'b0; we = 1'b0; addr_in = 16'hFFFF; wdata_in = 8'hFF;
        for (int k = 1; k <= 4; k++) begin
            tick;
            chk($sformatf("wr N+%0d strobe", k), 32'(o_wr[0]),
                32'(k == 1 || k == 2));
            chk($sformatf("wr N+%0d no read", k), 32'(o_rd[0]), 32'd0);
            chk($sformatf("wr N+%0d addr", k), 32'(o_maddr[0]), 32'h0020);
            chk($sformatf("wr N+%0d data", k), 32'(o_mwd[0]), 32'h005C);
        end
        chk("wr ack", 32'(o_ack[0]), 32'd1);
        chk("wr rdata kept", 32'(o_rdat[0]), 32'h00A5);
        repeat (4) tick;

        // Back-to-back: drop req while busy, accept right after ack
        req = 1'b1; we = 1'b1; addr_in = 16'h0100; wdata_in = 8'h11;
        tick;
        req = 1'b0;
        tick;
        req = 1'b1; addr_in = 16'h0055;
        tick;
        req = 1'b0;
        acks = 0;
        ack_k.delete();
        for (int k = 3; k <= 12; k++) begin
            tick;
            if (o_ack[0]) begin
                acks++;
                ack_k.push_back(k);
            end
            req = (k == 5);
            addr_in = 16'h0200;
        end
        chk("b2b ack count", 32'(acks), 32'd2);
        chk("b2b first ack", 32'(ack_k.size() > 0 ? ack_k[0] : -1), 32'd4);
        chk("b2b second ack", 32'(ack_k.size() > 1 ? ack_k[1] : -1), 32'd10);
        chk("b2b addr", 32'(o_maddr[0]), 32'h0200);
        repeat (3) tick;

        // Abort in the first strobe cycle
        mem_rdata = 8'h3C;
        req = 1'b1; we = 1'b0; addr_in = 16'h0004;
        tick;
        req = 1'b0;
        tick;
        chk("ab strobe on", 32'(o_rd[0]), 32'd1);
        run_en = 1'b0;
        tick;
        chk("ab abort", 32'(o_abort[0]), 32'd1);
        chk("ab strobe off", 32'(o_rd[0]), 32'd0);
        chk("ab busy", 32'(o_busy[0]), 32'd0);
        tick;
        chk("ab abort pulse", 32'(o_abort[0]), 32'd0);
        acks = 0;
        repeat (4) begin
            tick;
            if (o_ack[0]) acks++;
        end
        chk("ab no ack", 32'(acks), 32'd0);
        chk("ab rdata kept", 32'(o_rdat[0]), 32'h00A5);

        // Request while not running is ignored
        req = 1'b1; we = 1'b1;
        tick;
        req = 1'b0;
        acks = 0;
        repeat (6) begin
            tick;
            if (o_ack[0] || o_rd[0] || o_wr[0] || o_busy[0]) acks++;
        end
        chk("idle req ignored", 32'(acks), 32'd0);

        // Asynchronous reset mid-transaction
        run_en = 1'b1;
        req = 1'b1; we = 1'b1; addr_in = 16'h1234; wdata_in = 8'h9A;
        tick;
        req = 1'b0;
        tick;
        chk("mid wr strobe", 32'(o_wr[0]), 32'd1);
        #2 reset = 1'b0;
        #1 chk_zero("async reset");
        tick;
        reset = 1'b1;
        tick;

        // Randomised traffic checked by the model
        for (int n = 0; n < 3000; n++) begin
            run_en    = ($urandom % 16) != 0;
            req       = ($urandom % 3) == 0;
            we        = 1'($urandom % 2);
            addr_in   = 16'($urandom);
            wdata_in  = 8'($urandom);
            mem_rdata = 8'($urandom);
            tick;
        end
        req = 1'b0;
        repeat (10) tick;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
